// File: rtl/onewire_byte_engine_if.sv
// onewire_byte_engine_if
//   Request/status bundle between a caller and the 1-Wire byte engine.
//   reset_req/write_req/read_req : one-level requests, honoured only while idle
//   in_byte                      : byte to transmit, captured when a write starts
//   out_byte                     : last byte received (LSB arrives first)
//   presence                     : a slave answered the most recent bus reset
//   busy                         : high for the whole duration of a sequence
//   master modport = caller side, slave modport = engine side.
interface onewire_byte_engine_if;
    logic       reset_req;
    logic       write_req;
    logic       read_req;
    logic [7:0] in_byte;
    logic [7:0] out_byte;
    logic       presence;
    logic       busy;

    modport master (
        output reset_req, write_req, read_req, in_byte,
        input  out_byte, presence, busy
    );

    modport slave (
        input  reset_req, write_req, read_req, in_byte,
        output out_byte, presence, busy
    );
endinterface

// File: rtl/onewire_byte_engine.sv
// onewire_byte_engine
//   Generates 1-Wire reset/presence sequences and 8-slot byte writes/reads on
//   an open-drain line. All timing is built from a microsecond prescaler.
//   Ports:
//     CLK_10MHZ  : system clock, everything on its rising edge
//     rst        : synchronous active-high reset
//     bus        : request/status bundle (engine side)
//     oneWirePin : open-drain line, only ever driven low or released
module onewire_byte_engine #(
    parameter int CLK_PER_US = 10
) (
    input  logic                        CLK_10MHZ,
    input  logic                        rst,
    onewire_byte_engine_if.slave        bus,
    inout  wire                         oneWirePin
);
    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    localparam logic [8:0] RST_LOW_LAST    = 9'(480 - 1);
    localparam logic [8:0] RST_SAMPLE_LAST = 9'(70 - 1);
    localparam logic [8:0] RST_RECOV_LAST  = 9'(410 - 1);
    localparam logic [8:0] SLOT_LAST       = 9'(70 - 1);
    localparam logic [8:0] LONG_LOW_US     = 9'd60;
    localparam logic [8:0] SHORT_LOW_US    = 9'd6;
    localparam logic [8:0] READ_SAMPLE_US  = 9'd14;

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_SAMPLE, RST_RECOV, SLOT_LOW, SLOT_REL
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [8:0]       us_q, us_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             is_read_q, is_read_d;
    logic             rd_bit_q, rd_bit_d;
    logic             busy_q, busy_d;
    logic             presence_q, presence_d;
    logic [7:0]       out_q, out_d;

    logic             us_tick;
    logic             pin_in;
    logic             drive_low;
    logic [8:0]       low_us;

    // Open-drain: the line is only ever pulled low; the pull-up makes the 1.
    assign drive_low  = (state_q == RST_LOW) || (state_q == SLOT_LOW);
    assign oneWirePin = drive_low ? 1'b0 : 1'bz;
    assign pin_in     = oneWirePin;

    assign us_tick = (pre_q == PRE_W'(CLK_PER_US - 1));

    // Write-0 holds the line for 60 us; write-1 and read slots only for 6 us.
    // The shift register is consumed LSB first, so bit 0 is the current bit.
    assign low_us = (is_read_q || shift_q[0]) ? SHORT_LOW_US : LONG_LOW_US;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        us_d       = us_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        is_read_d  = is_read_q;
        rd_bit_d   = rd_bit_q;
        presence_d = presence_q;
        out_d      = out_q;

        if (state_q != IDLE) begin
            pre_d = us_tick ? '0 : pre_q + 1'b1;
            if (us_tick) begin
                us_d = us_q + 9'd1;
            end
        end

        case (state_q)
            IDLE: begin
                // Fixed priority: reset, then write, then read.
                if (bus.reset_req) begin
                    state_d = RST_LOW;
                    pre_d   = '0;
                    us_d    = '0;
                end else if (bus.write_req) begin
                    state_d   = SLOT_LOW;
                    shift_d   = bus.in_byte;
                    is_read_d = 1'b0;
                    bit_d     = 3'd0;
                    pre_d     = '0;
                    us_d      = '0;
                end else if (bus.read_req) begin
                    state_d   = SLOT_LOW;
                    shift_d   = 8'h00;
                    is_read_d = 1'b1;
                    bit_d     = 3'd0;
                    pre_d     = '0;
                    us_d      = '0;
                end
            end
            RST_LOW: begin
                if (us_tick && us_q == RST_LOW_LAST) begin
                    state_d = RST_SAMPLE;
                    us_d    = '0;
                end
            end
            RST_SAMPLE: begin
                if (us_tick && us_q == RST_SAMPLE_LAST) begin
                    // A slave answering the reset holds the line low here.
                    presence_d = ~pin_in;
                    state_d    = RST_RECOV;
                    us_d       = '0;
                end
            end
            RST_RECOV: begin
                if (us_tick && us_q == RST_RECOV_LAST) begin
                    state_d = IDLE;
                    us_d    = '0;
                end
            end
            SLOT_LOW: begin
                // us_q keeps counting through the release phase so it always
                // holds the microsecond position within the whole slot.
                if (us_tick && us_q == low_us - 9'd1) begin
                    state_d = SLOT_REL;
                end
            end
            SLOT_REL: begin
                if (is_read_q && us_tick && us_q == READ_SAMPLE_US) begin
                    rd_bit_d = pin_in;
                end
                if (us_tick && us_q == SLOT_LAST) begin
                    us_d    = '0;
                    shift_d = {is_read_q ? rd_bit_q : 1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = IDLE;
                        if (is_read_q) begin
                            out_d = shift_d;
                        end
                    end else begin
                        state_d = SLOT_LOW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // busy is registered from the next state so it rises the cycle after
        // acceptance and falls exactly when the FSM lands back in IDLE.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            us_q       <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            is_read_q  <= 1'b0;
            rd_bit_q   <= 1'b0;
            busy_q     <= 1'b0;
            presence_q <= 1'b0;
            out_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            us_q       <= us_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            is_read_q  <= is_read_d;
            rd_bit_q   <= rd_bit_d;
            busy_q     <= busy_d;
            presence_q <= presence_d;
            out_q      <= out_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.presence = presence_q;
    assign bus.out_byte = out_q;
endmodule

// File: doc/onewire_byte_engine.md
ONEWIRE_BYTE_ENGINE -- requirements
Module: onewire_byte_engine

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 10, clock cycles per microsecond; all slot timing derives from it.
REQ-002 SHALL have port CLK_10MHZ  input  1  system clock; one clock only, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port reset_req  input  1  request a bus reset/presence sequence.
REQ-005 SHALL have port write_req  input  1  request a byte write of in_byte.
REQ-006 SHALL have port read_req  input  1  request a byte read into out_byte.
REQ-007 SHALL have port in_byte  input  8  byte to write, sampled at request acceptance.
REQ-008 SHALL have port out_byte  output  8  last byte read, LSB received first.
REQ-009 SHALL have port presence  output  1  1 = slave answered the last reset.
REQ-010 SHALL have port busy  output  1  registered; high while a sequence runs.
REQ-011 SHALL have port oneWirePin  inout  1  open-drain bus line: driven 0 or high-Z, never driven 1.

Function
REQ-012 SHALL accept a request only when busy=0; busy rises the cycle after acceptance; requests while busy are ignored, not queued.
REQ-013 SHALL apply priority reset_req > write_req > read_req when several are high in the same idle cycle.
REQ-014 SHALL, while a request input is held high, start a new sequence on the first idle cycle after busy falls.
REQ-015 SHALL implement states IDLE, RST_LOW, RST_SAMPLE, RST_RECOV, SLOT_LOW, SLOT_REL, with a per-microsecond prescaler restarted at acceptance.
REQ-016 SHALL run a reset as follows: RST_LOW drives the pin low 480 us; RST_SAMPLE releases it 70 us; RST_RECOV releases it 410 us more.
REQ-017 SHALL, at the last cycle of RST_SAMPLE, set presence=1 if the pin reads 0, else presence=0.
REQ-018 SHALL hold busy for exactly 960*CLK_PER_US cycles per reset (9600 cycles at the default).
REQ-019 SHALL run each byte as 8 slots of 70 us, LSB first; busy high exactly 560*CLK_PER_US cycles (5600 at the default).
REQ-020 SHALL drive write-0 slots low for 60 us, then release for 10 us.
REQ-021 SHALL drive write-1 slots low for 6 us, then release for 64 us.
REQ-022 SHALL drive read slots low for 6 us and release for 64 us, sampling the pin at the last cycle of slot microsecond 14; the sample is the data bit.
REQ-023 SHALL shift read bits into an internal register; out_byte SHALL update only on the cycle busy falls after a read, and otherwise hold.
REQ-024 SHALL not alter out_byte on write or reset sequences, nor presence on byte sequences.
REQ-025 SHALL have busy fall on the same cycle the FSM returns to IDLE, so the caller sees exactly one busy 1->0 edge per sequence.
REQ-026 SHALL release the pin (high-Z) in IDLE and on every slot release phase.
REQ-027 SHALL compute bit index 0..7 with a 3-bit counter; wrap from 7 ends the byte with no 9th slot.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-slot, release the pin and force state=IDLE, busy=0, out_byte=8'h00, presence=0, prescaler=0, bit index=0 on the next edge.
REQ-029 SHALL ignore request inputs during the cycle rst is high; rst has priority over all requests.

Verification
REQ-030 Reset with a slave pulling the pin low 60-240 us after release -> pin low 4800 cycles, busy high 9600 cycles, presence=1.
REQ-031 Reset with no slave (pull-up only) -> presence=0, busy timing identical to the slave case.
REQ-032 write_req with in_byte=8'hCC -> slot low times 600,600,60,60,600,600,60,60 cycles, 700-cycle slots, busy 5600 cycles.
REQ-033 read_req with a slave model returning 8'h50 -> out_byte=8'h50 on the busy falling edge, and unchanged before it.
REQ-034 reset_req and write_req high on the same idle cycle -> reset executes; write_req held high starts the write on the first idle cycle after busy falls.
REQ-035 rst asserted at cycle 300 of a write-0 slot -> pin high-Z and busy=0 on the next edge, out_byte=0; a following read_req completes normally.
